full_adder: RTL and testbench

- Parameterizable ripple-carry full adder with registered outputs; WIDTH=1 (default) is the classic one-bit full adder: a_in + b_in + c_in -> {carry_out, sum_out}.
- Used as the arithmetic leaf cell of the datapath and as a building block for wider adders.
- Internally a chain of one-bit full-adder cells, with a single output register stage and a valid flag.

---
 rtl/full_adder.sv | 78 +++++++
 tb/tb_full_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// full_adder: ripple-carry adder built from one-bit full-adder cells, with an
// optional single output register stage and a valid flag.
//
// Parameters:
//   WIDTH   - operand width in bits (>= 1); WIDTH=1 is the classic full adder
//   REG_OUT - 1: outputs registered, 1-cycle latency
//             0: outputs combinational, out_valid follows in_valid directly
//
// Ports:
//   clk          in   system clock, rising edge (unused when REG_OUT=0)
//   rst_n        in   synchronous active-low reset (unused when REG_OUT=0)
//   a_in         in   operand A, unsigned, WIDTH bits
//   b_in         in   operand B, unsigned, WIDTH bits
//   c_in         in   carry-in
//   in_valid     in   qualifies a_in/b_in/c_in this cycle
//   sum_out      out  (a_in + b_in + c_in) mod 2^WIDTH
//   carry_out    out  carry out of the MSB
//   overflow_out out  signed overflow: carry into MSB xor carry out of MSB
//   out_valid    out  result outputs hold a valid result
module full_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out,
  output logic             out_valid
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic             ovf;

  assign c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]   = a_in[i] ^ b_in[i] ^ c[i];
    assign c[i+1] = (a_in[i] & b_in[i]) | (a_in[i] & c[i]) | (b_in[i] & c[i]);
  end

  // For WIDTH=1 the carry into the MSB is c_in itself.
  assign ovf = c[WIDTH-1] ^ c[WIDTH];

  if (REG_OUT) begin : g_reg
    // Data registers update every cycle regardless of in_valid; only
    // out_valid tells the consumer whether the data is meaningful.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sum_out      <= '0;
        carry_out    <= 1'b0;
        overflow_out <= 1'b0;
        out_valid    <= 1'b0;
      end else begin
        sum_out      <= s;
        carry_out    <= c[WIDTH];
        overflow_out <= ovf;
        out_valid    <= in_valid;
      end
    end
  end else begin : g_comb
    // Clock and reset have no function in the combinational variant.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign sum_out      = s;
    assign carry_out    = c[WIDTH];
    assign overflow_out = ovf;
    assign out_valid    = in_valid;
  end

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=1, registered
  logic [0:0] a1 = '0, b1 = '0;
  logic       c1 = 1'b0, v1 = 1'b0;
  logic [0:0] sum1;
  logic       carry1, ovf1, vld1;

  // WIDTH=8, registered
  logic [7:0] a8 = '0, b8 = '0;
  logic       c8 = 1'b0, v8 = 1'b0;
  logic [7:0] sum8;
  logic       carry8, ovf8, vld8;

  // WIDTH=1, combinational
  logic [0:0] ac = '0, bc = '0;
  logic       cc = 1'b0, vc = 1'b0;
  logic [0:0] sumc;
  logic       carryc, ovfc, vldc;

  exp_t q1[$];
  exp_t q8[$];

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a_in(a1), .b_in(b1), .c_in(c1), .in_valid(v1),
    .sum_out(sum1), .carry_out(carry1), .overflow_out(ovf1), .out_valid(vld1)
  );

  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .a_in(a8), .b_in(b8), .c_in(c8), .in_valid(v8),
    .sum_out(sum8), .carry_out(carry8), .overflow_out(ovf8), .out_valid(vld8)
  );

  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) dutc (
    .clk(clk), .rst_n(rst_n), .a_in(ac), .b_in(bc), .c_in(cc), .in_valid(vc),
    .sum_out(sumc), .carry_out(carryc), .overflow_out(ovfc), .out_valid(vldc)
  );

  // Reference: exact integer arithmetic; overflow means the signed sum does
  // not fit in a WIDTH-bit two's-complement result.
  function automatic exp_t ref_add(int w, logic [7:0] a, logic [7:0] b, logic c);
    exp_t r;
    int total, sa, sb, ssum, lim;
    lim   = 1 << w;
    total = int'(a) + int'(b) + int'(c);
    sa    = (int'(a) >= lim / 2) ? int'(a) - lim : int'(a);
    sb    = (int'(b) >= lim / 2) ? int'(b) - lim : int'(b);
    ssum  = sa + sb + int'(c);
    r.sum   = 8'(total % lim);
    r.carry = (total / lim) != 0;
    r.ovf   = (ssum > lim / 2 - 1) || (ssum < -(lim / 2));
    return r;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step1(logic r, logic a, logic b, logic c, logic v);
    @(negedge clk);
    rst_n = r; a1 = a; b1 = b; c1 = c; v1 = v;
    if (r && v) q1.push_back(ref_add(1, {7'b0, a}, {7'b0, b}, c));
  endtask

  task automatic step8(logic r, logic [7:0] a, logic [7:0] b, logic c, logic v);
    @(negedge clk);
    rst_n = r; a8 = a; b8 = b; c8 = c; v8 = v;
    if (r && v) q8.push_back(ref_add(8, a, b, c));
  endtask

  // Monitor: inputs are stable from the negedge to the next negedge, so at
  // posedge+1 they still describe what the DUT just captured.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("reset_w1", {12'b0, sum1, carry1, ovf1, vld1}, 16'h0);
        chk("reset_w8", {5'b0, sum8, carry8, ovf8, vld8}, 16'h0);
      end else begin
        chk("valid_w1", {15'b0, vld1}, {15'b0, v1});
        chk("valid_w8", {15'b0, vld8}, {15'b0, v8});
        if (vld1) begin
          if (q1.size() == 0) chk("unexpected_w1", 16'h1, 16'h0);
          else begin
            e = q1.pop_front();
            chk("result_w1", {13'b0, carry1, sum1, ovf1}, {13'b0, e.carry, e.sum[0], e.ovf});
          end
        end
        if (vld8) begin
          if (q8.size() == 0) chk("unexpected_w8", 16'h1, 16'h0);
          else begin
            e = q8.pop_front();
            chk("result_w8", {6'b0, carry8, sum8, ovf8}, {6'b0, e.carry, e.sum, e.ovf});
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] bits;
    exp_t e;

    // Reset, then WIDTH=1 exhaustive
    step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bits = 3'(i);
      step1(1'b1, bits[2], bits[1], bits[0], 1'b1);
    end

    // Reset held two cycles with valid ones on the inputs, then released
    step1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // WIDTH=8 carry chain and boundary operands
    step8(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
    step8(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1);
    step8(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
    step8(1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
    step8(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);

    // Valid gating with random operands
    for (int i = 0; i < 6; i++)
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), (i % 2) == 0);

    // Mid-stream reset discards the in-flight input
    step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    step8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);

    // Random back-to-back traffic with random valid
    for (int i = 0; i < 40; i++)
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    step8(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    step8(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain_w1", 16'(q1.size()), 16'h0);
    chk("drain_w8", 16'(q8.size()), 16'h0);

    // Combinational variant: truth table, out_valid follows in_valid
    for (int i = 0; i < 8; i++) begin
      bits = 3'(i);
      ac = bits[2]; bc = bits[1]; cc = bits[0]; vc = (i % 3) != 0;
      e = ref_add(1, {7'b0, bits[2]}, {7'b0, bits[1]}, bits[0]);
      #1;
      chk("comb_w1", {12'b0, carryc, sumc, ovfc, vldc}, {12'b0, e.carry, e.sum[0], e.ovf, vc});
      #9;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
